// File: rtl/rmu.sv
// rmu: USB full-speed receive control unit; frames bits/bytes, checks SYNC/PID, pushes payload to the RX FIFO.
// Optional PID_CHECK_EN: also require PID[7:4] to be the complement of PID[3:0].
module rmu #(
  parameter logic [7:0] SYNC_BYTE = 8'h80,
  parameter int         MAX_DATA  = 64
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       d_edge,
  input  logic       shift_enable,
  input  logic       eop,
  input  logic [7:0] rcv_data,
  input  logic [6:0] buffer_occupancy,
  output logic       rcving,
  output logic [3:0] rx_packet,
  output logic [7:0] rx_packet_data,
  output logic       store_rx_packet_data,
  output logic       flush,
  output logic       rx_data_ready,
  output logic       rx_transfer_active,
  output logic       rx_error
);
  typedef enum logic [3:0] {
    IDLE, SYNC_RCV, SYNC_CHK, PID_RCV, PID_CHK, DATA_RCV, DATA_STORE,
    EOP_WAIT, EOP_END, ERR_WAIT, ERR_EOP, ERR_IDLE
  } state_t;

  localparam logic [6:0] MAX_OCC = 7'(MAX_DATA);

  state_t     r_state, w_next;
  logic [2:0] r_bit_cnt;
  logic [6:0] r_byte_cnt;
  logic       r_byte_done, r_is_data;
  logic [3:0] r_rx_packet;

  logic w_rcv_st, w_clr, w_cnt_inc, w_pid_load, w_store, w_flush, w_ready;
  logic w_hs, w_tok, w_data, w_pid_ok, w_se_eop, w_eop_aligned;

  assign w_rcv_st = (r_state == SYNC_RCV) || (r_state == PID_RCV) || (r_state == DATA_RCV);
  assign w_se_eop = shift_enable && eop;
  assign w_hs     = rcv_data[3:0] inside {4'h2, 4'hA, 4'hE};
  assign w_tok    = rcv_data[3:0] inside {4'h1, 4'h9, 4'hD};
  assign w_data   = rcv_data[3:0] inside {4'h3, 4'hB};
`ifdef PID_CHECK_EN
  assign w_pid_ok = (rcv_data[7:4] == ~rcv_data[3:0]);
`else
  assign w_pid_ok = 1'b1;
`endif
  // SE0 must land on a byte boundary after exactly 2 token bytes or at least 2 data bytes (CRC16)
  assign w_eop_aligned = (r_bit_cnt == 3'd0) &&
                         (r_is_data ? (r_byte_cnt >= 7'd2) : (r_byte_cnt == 7'd2));

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state     <= IDLE;
      r_bit_cnt   <= '0;
      r_byte_cnt  <= '0;
      r_byte_done <= 1'b0;
      r_is_data   <= 1'b0;
      r_rx_packet <= '0;
    end else begin
      r_state     <= w_next;
      r_byte_done <= w_rcv_st && shift_enable && (r_bit_cnt == 3'd7);
      if (w_clr)
        r_bit_cnt <= '0;
      else if (w_rcv_st && shift_enable)
        r_bit_cnt <= r_bit_cnt + 3'd1;
      if (w_clr)
        r_byte_cnt <= '0;
      else if (w_cnt_inc && (r_byte_cnt != 7'd127))
        r_byte_cnt <= r_byte_cnt + 7'd1;
      if (w_pid_load) begin
        r_rx_packet <= rcv_data[3:0];
        r_is_data   <= w_data;
      end
    end
  end

  always_comb begin
    w_next     = r_state;
    w_clr      = 1'b0;
    w_cnt_inc  = 1'b0;
    w_pid_load = 1'b0;
    w_store    = 1'b0;
    w_flush    = 1'b0;
    w_ready    = 1'b0;
    case (r_state)
      IDLE, ERR_IDLE:
        if (d_edge) begin
          w_next  = SYNC_RCV;
          w_flush = 1'b1;
          w_clr   = 1'b1;
        end
      SYNC_RCV: if (r_byte_done) w_next = SYNC_CHK;
      SYNC_CHK: w_next = (rcv_data == SYNC_BYTE) ? PID_RCV : ERR_WAIT;
      PID_RCV:
        if (w_se_eop)         w_next = ERR_WAIT;
        else if (r_byte_done) w_next = PID_CHK;
      PID_CHK: begin
        w_pid_load = 1'b1;
        if (!w_pid_ok)              w_next = ERR_WAIT;
        else if (w_hs)              w_next = EOP_WAIT;
        else if (w_data || w_tok)   w_next = DATA_RCV;
        else                        w_next = ERR_WAIT;
      end
      DATA_RCV:
        if (w_se_eop)         w_next = w_eop_aligned ? EOP_WAIT : ERR_WAIT;
        else if (r_byte_done) w_next = DATA_STORE;
      DATA_STORE: begin
        w_cnt_inc = 1'b1;
        if (!r_is_data)
          w_next = (r_byte_cnt == 7'd2) ? ERR_WAIT : DATA_RCV;
        else if (buffer_occupancy >= MAX_OCC)
          w_next = ERR_WAIT;
        else begin
          w_store = 1'b1;
          w_next  = DATA_RCV;
        end
      end
      EOP_WAIT: if (shift_enable) w_next = eop ? EOP_END : ERR_WAIT;
      EOP_END:
        if (d_edge) begin
          w_next  = IDLE;
          w_ready = 1'b1;
        end
      ERR_WAIT: if (w_se_eop) w_next = ERR_EOP;
      ERR_EOP:  if (d_edge)   w_next = ERR_IDLE;
      default:  w_next = IDLE;
    endcase
  end

  assign rcving               = (r_state != IDLE) && (r_state != ERR_IDLE);
  assign rx_error             = (r_state == ERR_WAIT) || (r_state == ERR_EOP) || (r_state == ERR_IDLE);
  assign rx_transfer_active   = r_is_data && ((r_state == DATA_RCV) || (r_state == DATA_STORE));
  assign rx_packet            = r_rx_packet;
  assign rx_packet_data       = w_store ? rcv_data : 8'h00;
  assign store_rx_packet_data = w_store;
  assign flush                = w_flush;
  assign rx_data_ready        = w_ready;
endmodule

// File: tb/tb_rmu.sv
// Scoreboard bench for rmu: a packet-level model queues expected FIFO pushes, flushes, ready pulses and status snapshots.
module tb_rmu;
  logic       clk = 1'b0, n_rst = 1'b0, d_edge = 1'b0, shift_enable = 1'b0, eop = 1'b0;
  logic [7:0] rcv_data = 8'h00;
  logic [6:0] buffer_occupancy = 7'd0;
  logic       rcving, store_rx_packet_data, flush, rx_data_ready, rx_transfer_active, rx_error;
  logic [3:0] rx_packet;
  logic [7:0] rx_packet_data;

  rmu dut (
    .clk(clk), .n_rst(n_rst), .d_edge(d_edge), .shift_enable(shift_enable), .eop(eop),
    .rcv_data(rcv_data), .buffer_occupancy(buffer_occupancy), .rcving(rcving),
    .rx_packet(rx_packet), .rx_packet_data(rx_packet_data),
    .store_rx_packet_data(store_rx_packet_data), .flush(flush),
    .rx_data_ready(rx_data_ready), .rx_transfer_active(rx_transfer_active), .rx_error(rx_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         kind;
    logic [7:0] data;
    logic       err;
    logic       rcv;
    logic [3:0] pid;
    logic       chk_act;
    logic       act;
  } ev_t;

  localparam int K_STORE = 0, K_READY = 1, K_FLUSH = 2, K_STAT = 3, K_RST = 4, K_END = 5;

  ev_t        q[$];
  int         checks = 0;
  int         errors = 0;
  logic       req = 1'b0;
  logic       act_seen = 1'b0;
  logic [3:0] m_pid = 4'h0;
  logic [7:0] pl [8];
  logic [7:0] pid_tab [10] = '{8'hD2, 8'h5A, 8'h1E, 8'hC3, 8'h4B, 8'hE1, 8'h69, 8'h2D, 8'hF0, 8'h87};

  function automatic ev_t mk(input int kind, input logic [7:0] d, input logic err, input logic rcv,
                             input logic [3:0] pid, input logic chk_act, input logic act);
    ev_t e;
    e.kind = kind; e.data = d; e.err = err; e.rcv = rcv; e.pid = pid; e.chk_act = chk_act; e.act = act;
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic pop_cmp(input int kind, input logic [7:0] d);
    ev_t e;
    checks++;
    if (q.size() == 0) begin
      errors++;
      $display("FAIL event: kind %0d data %02h seen, nothing expected", kind, d);
      return;
    end
    e = q.pop_front();
    if (e.kind != kind || e.data != d) begin
      errors++;
      $display("FAIL event: got kind %0d data %02h, expected kind %0d data %02h", kind, d, e.kind, e.data);
    end
  endtask

  task automatic service_req();
    ev_t e;
    while (q.size() > 0 && q[0].kind < K_STAT) begin
      checks++;
      errors++;
      $display("FAIL missing event: expected kind %0d data %02h never seen", q[0].kind, q[0].data);
      void'(q.pop_front());
    end
    if (q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL status: request with empty scoreboard");
      return;
    end
    e = q.pop_front();
    case (e.kind)
      K_STAT: begin
        chk("rx_error", 32'(rx_error), 32'(e.err));
        chk("rcving", 32'(rcving), 32'(e.rcv));
        chk("rx_packet", 32'(rx_packet), 32'(e.pid));
        if (e.chk_act) chk("rx_transfer_active seen", 32'(act_seen), 32'(e.act));
      end
      K_RST: chk("reset outputs", 32'({rcving, rx_packet, rx_packet_data, store_rx_packet_data,
                                       flush, rx_data_ready, rx_transfer_active, rx_error}), 32'd0);
      default: chk("scoreboard drained", 32'(q.size()), 32'd0);
    endcase
  endtask

  // Monitor: every DUT strobe pops the scoreboard; status snapshots are taken on request
  always @(negedge clk) begin
    if (n_rst) begin
      if (rx_transfer_active) act_seen = 1'b1;
      if (flush) begin
        act_seen = 1'b0;
        pop_cmp(K_FLUSH, 8'h00);
      end
      if (store_rx_packet_data) pop_cmp(K_STORE, rx_packet_data);
      if (rx_data_ready) pop_cmp(K_READY, 8'h00);
    end
    if (req) service_req();
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic request();
    req = 1'b1; tick();
    req = 1'b0; tick();
  endtask

  task automatic send_bit(input logic b, input logic e);
    shift_enable = 1'b1; eop = e; tick();
    shift_enable = 1'b0; eop = 1'b0; rcv_data = {b, rcv_data[7:1]};
    tick(); tick(); tick(); tick();
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 0; i < 8; i++) send_bit(b[i], 1'b0);
  endtask

  task automatic pulse_edge();
    d_edge = 1'b1; tick();
    d_edge = 1'b0; tick(); tick();
  endtask

  task automatic start_pkt();
    q.push_back(mk(K_FLUSH, 8'h00, 0, 0, 0, 0, 0));
    q.push_back(mk(K_STAT, 8'h00, 1'b0, 1'b1, m_pid, 1'b0, 1'b0));
    pulse_edge();
    request();
  endtask

  // Packet-level reference: decide outcome from SYNC, PID class, byte count, trailing bits, FIFO room
  task automatic run_pkt(input logic [7:0] sync, input logic [7:0] pid, input int n, input int k, input int base);
    logic [3:0] p;
    logic       hs, tok, dat, valid, err;
    int         nst;
    p   = pid[3:0];
    hs  = (p == 4'h2) || (p == 4'hA) || (p == 4'hE);
    tok = (p == 4'h1) || (p == 4'h9) || (p == 4'hD);
    dat = (p == 4'h3) || (p == 4'hB);
    valid = hs || tok || dat;
`ifdef PID_CHECK_EN
    if (pid[7:4] != ~pid[3:0]) valid = 1'b0;
`endif
    start_pkt();
    err = 1'b0;
    nst = 0;
    if (sync != 8'h80) err = 1'b1;
    else begin
      m_pid = p;
      if (!valid)   err = 1'b1;
      else if (hs)  err = (n != 0) || (k != 0);
      else if (tok) err = (n != 2) || (k != 0);
      else begin
        for (int i = 0; i < n; i++) begin
          if (base + i >= 64) begin err = 1'b1; break; end
          nst++;
        end
        if (!err && (n < 2 || k != 0)) err = 1'b1;
      end
    end
    for (int i = 0; i < nst; i++) q.push_back(mk(K_STORE, pl[i], 0, 0, 0, 0, 0));
    if (!err) q.push_back(mk(K_READY, 8'h00, 0, 0, 0, 0, 0));

    buffer_occupancy = 7'(base);
    send_byte(sync);
    send_byte(pid);
    for (int i = 0; i < n; i++) begin
      buffer_occupancy = 7'(base + i);
      send_byte(pl[i]);
    end
    for (int i = 0; i < k; i++) send_bit(1'($urandom), 1'b0);
    send_bit(1'b0, 1'b1);
    send_bit(1'b0, 1'b1);
    pulse_edge();
    q.push_back(mk(K_STAT, 8'h00, err, 1'b0, m_pid, 1'b1, (sync == 8'h80) && valid && dat));
    request();
  endtask

  initial begin
    tick(); tick();
    q.push_back(mk(K_RST, 8'h00, 0, 0, 0, 0, 0));
    request();
    n_rst = 1'b1;
    tick();

    run_pkt(8'h80, 8'hD2, 0, 0, 0);                       // ACK
    pl[0] = 8'h11; pl[1] = 8'h22; pl[2] = 8'h33; pl[3] = 8'hC1; pl[4] = 8'hC2;
    run_pkt(8'h80, 8'hC3, 5, 0, 10);                      // DATA0, 3 bytes + CRC16
    run_pkt(8'h81, 8'hD2, 0, 0, 0);                       // bad SYNC
    run_pkt(8'h80, 8'hC3, 1, 4, 0);                       // SE0 after 4 payload bits
    run_pkt(8'h80, 8'h4B, 3, 0, 64);                      // FIFO full at first store
    run_pkt(8'h80, 8'h4B, 4, 0, 62);                      // FIFO fills mid-packet
    run_pkt(8'h80, 8'hC2, 0, 0, 0);                       // PID with bad complement
    run_pkt(8'h80, 8'hE1, 2, 0, 0);                       // OUT token
    run_pkt(8'h80, 8'h69, 3, 0, 0);                       // IN token, one byte too many
    run_pkt(8'h80, 8'hF0, 0, 0, 0);                       // reserved PID

    // reset mid-packet: one byte already pushed, nothing after
    start_pkt();
    pl[0] = 8'h5C;
    q.push_back(mk(K_STORE, pl[0], 0, 0, 0, 0, 0));
    buffer_occupancy = 7'd0;
    send_byte(8'h80);
    send_byte(8'hC3);
    send_byte(pl[0]);
    for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0);
    n_rst = 1'b0;
    tick();
    q.push_back(mk(K_RST, 8'h00, 0, 0, 0, 0, 0));
    request();
    n_rst = 1'b1;
    m_pid = 4'h0;
    tick();
    q.push_back(mk(K_STAT, 8'h00, 1'b0, 1'b0, m_pid, 1'b0, 1'b0));
    request();

    for (int t = 0; t < 36; t++) begin
      logic [7:0] s, p;
      int n, k, base;
      s = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'h80;
      p = ($urandom_range(0, 5) == 0) ? 8'($urandom) : pid_tab[$urandom_range(0, 9)];
      n = $urandom_range(0, 6);
      k = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
      base = ($urandom_range(0, 4) == 0) ? $urandom_range(58, 70) : $urandom_range(0, 50);
      for (int i = 0; i < 8; i++) pl[i] = 8'($urandom);
      run_pkt(s, p, n, k, base);
    end

    q.push_back(mk(K_END, 8'h00, 0, 0, 0, 0, 0));
    request();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
